// File: rtl/i2c_frame_slave_if.sv
// Frame-buffer RAM port between the I2C frame slave and its synchronous memory.
// The slave (master modport) owns address/strobes/write data; the RAM returns read data.
interface i2c_frame_slave_if #(
  parameter int SEG_W = 8,
  parameter int OFF_W = 8
);
  logic [SEG_W+OFF_W-1:0] mem_addr;
  logic                   mem_rd;
  logic [7:0]             mem_rdata;
  logic                   mem_wr;
  logic [7:0]             mem_wdata;

  modport master (output mem_addr, output mem_rd, output mem_wr, output mem_wdata,
                  input  mem_rdata);
  modport slave  (input  mem_addr, input  mem_rd, input  mem_wr, input  mem_wdata,
                  output mem_rdata);
endinterface

// File: rtl/i2c_frame_slave.sv
// I2C slave giving burst/random access to the spinning-screen frame buffer.
// SCL/SDA are synchronised and glitch-filtered in the clk domain; the FSM walks
// address, segment/offset setup and data bytes, driving an external RAM port
// with an auto-incrementing {segment, offset} pointer.
module i2c_frame_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         SEG_W    = 8,
  parameter int         OFF_W    = 8,
  parameter int         NUM_SEG  = 256,
  parameter int         NUM_OFF  = 256,
  parameter int         FILT     = 3,
  parameter int         CARRY    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic [SEG_W-1:0]  seg_ptr,
  output logic [OFF_W-1:0]  off_ptr,
  i2c_frame_slave_if.master mem
);

  localparam int                 CNT_W     = (FILT < 2) ? 1 : $clog2(FILT);
  localparam logic [CNT_W-1:0]   FILT_LAST = CNT_W'(FILT - 1);
  localparam logic [8:0]         SEG_LIM   = 9'(NUM_SEG);
  localparam logic [8:0]         OFF_LIM   = 9'(NUM_OFF);
  localparam logic [SEG_W-1:0]   SEG_LAST  = SEG_W'(NUM_SEG - 1);
  localparam logic [OFF_W-1:0]   OFF_LAST  = OFF_W'(NUM_OFF - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    IGNORE   = 3'd3,
    WR_BYTE  = 3'd4,
    WR_ACK   = 3'd5,
    RD_BYTE  = 3'd6,
    RD_ACK   = 3'd7
  } state_t;

  // Input conditioning
  logic [1:0]       scl_sync_q, sda_sync_q;
  logic [CNT_W-1:0] scl_cnt_q, sda_cnt_q;
  logic             scl_f_q, sda_f_q, scl_p_q, sda_p_q;

  // Protocol state
  state_t           state_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic [1:0]       byte_idx_q;   // 0 = segment, 1 = offset, 2 = data (saturates)
  logic             ack_ph_q;     // inside an ACK slot: set on the 8th fall
  logic             rw_q;
  logic             latch_q;      // read data is on mem_rdata this cycle
  logic             sda_oe_q, busy_q, mem_rd_q, mem_wr_q;
  logic [7:0]       mem_wdata_q;
  logic [SEG_W-1:0] seg_q;
  logic [OFF_W-1:0] off_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign rx_byte   = {shift_q[6:0], sda_f_q};

  assign sda_oe        = sda_oe_q;
  assign busy          = busy_q;
  assign seg_ptr       = seg_q;
  assign off_ptr       = off_q;
  assign mem.mem_addr  = {seg_q, off_q};
  assign mem.mem_rd    = mem_rd_q;
  assign mem.mem_wr    = mem_wr_q;
  assign mem.mem_wdata = mem_wdata_q;

  // Next pointer: offset wraps at NUM_OFF-1, optionally carrying into the segment.
  function automatic logic [SEG_W+OFF_W-1:0] ptr_inc(input logic [SEG_W-1:0] seg,
                                                     input logic [OFF_W-1:0] off);
    logic [SEG_W-1:0] seg_n;
    logic [OFF_W-1:0] off_n;
    seg_n = seg;
    off_n = off + OFF_W'(1);
    if (off == OFF_LAST) begin
      off_n = {OFF_W{1'b0}};
      if (CARRY != 0) begin
        seg_n = (seg == SEG_LAST) ? {SEG_W{1'b0}} : seg + SEG_W'(1);
      end
    end
    return {seg_n, off_n};
  endfunction

  // Two-flop synchronisers followed by a FILT-cycle stability filter on each line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= {CNT_W{1'b0}};
      sda_cnt_q  <= {CNT_W{1'b0}};
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_p_q    <= scl_f_q;
      sda_p_q    <= sda_f_q;
      if (scl_sync_q[1] == scl_f_q) begin
        scl_cnt_q <= {CNT_W{1'b0}};
      end else if (scl_cnt_q == FILT_LAST) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= {CNT_W{1'b0}};
      end else begin
        scl_cnt_q <= scl_cnt_q + CNT_W'(1);
      end
      if (sda_sync_q[1] == sda_f_q) begin
        sda_cnt_q <= {CNT_W{1'b0}};
      end else if (sda_cnt_q == FILT_LAST) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= {CNT_W{1'b0}};
      end else begin
        sda_cnt_q <= sda_cnt_q + CNT_W'(1);
      end
    end
  end

  // Protocol FSM with registered SDA drive, RAM strobes and pointer updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= 2'd0;
      ack_ph_q    <= 1'b0;
      rw_q        <= 1'b0;
      latch_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      seg_q       <= {SEG_W{1'b0}};
      off_q       <= {OFF_W{1'b0}};
    end else begin
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      latch_q  <= mem_rd_q;
      // Pointer moves only after the RAM has consumed the current address.
      if (latch_q) begin
        shift_q <= mem.mem_rdata;
      end
      if (latch_q || mem_wr_q) begin
        {seg_q, off_q} <= ptr_inc(seg_q, off_q);
      end

      if (start_det) begin
        state_q    <= ADDR;
        sda_oe_q   <= 1'b0;
        bit_cnt_q  <= 3'd0;
        byte_idx_q <= 2'd0;
        ack_ph_q   <= 1'b0;
      end else if (stop_det) begin
        state_q    <= IDLE;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
        bit_cnt_q  <= 3'd0;
        byte_idx_q <= 2'd0;
        ack_ph_q   <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  rw_q     <= rx_byte[0];
                  busy_q   <= 1'b1;
                  ack_ph_q <= 1'b0;
                  state_q  <= ADDR_ACK;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= IGNORE;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall && !ack_ph_q) begin
              sda_oe_q <= 1'b1;
              ack_ph_q <= 1'b1;
              mem_rd_q <= rw_q;
            end else if (scl_fall && ack_ph_q) begin
              ack_ph_q  <= 1'b0;
              bit_cnt_q <= 3'd0;
              if (rw_q) begin
                sda_oe_q <= ~shift_q[7];
                shift_q  <= {shift_q[6:0], 1'b1};
                state_q  <= RD_BYTE;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= WR_BYTE;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                case (byte_idx_q)
                  2'd0: begin
                    if ({1'b0, rx_byte} < SEG_LIM) begin
                      seg_q   <= rx_byte[SEG_W-1:0];
                      state_q <= WR_ACK;
                    end else begin
                      state_q <= IGNORE;
                    end
                  end
                  2'd1: begin
                    if ({1'b0, rx_byte} < OFF_LIM) begin
                      off_q   <= rx_byte[OFF_W-1:0];
                      state_q <= WR_ACK;
                    end else begin
                      state_q <= IGNORE;
                    end
                  end
                  default: begin
                    mem_wdata_q <= rx_byte;
                    state_q     <= WR_ACK;
                  end
                endcase
              end
            end
          end
          WR_ACK: begin
            if (scl_fall && !ack_ph_q) begin
              sda_oe_q <= 1'b1;
              ack_ph_q <= 1'b1;
            end else if (scl_rise && ack_ph_q) begin
              mem_wr_q <= (byte_idx_q == 2'd2);
            end else if (scl_fall && ack_ph_q) begin
              sda_oe_q <= 1'b0;
              ack_ph_q <= 1'b0;
              if (byte_idx_q != 2'd2) begin
                byte_idx_q <= byte_idx_q + 2'd1;
              end
              state_q <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_ph_q <= 1'b0;
                state_q  <= RD_ACK;
              end
            end else if (scl_fall && (bit_cnt_q != 3'd0)) begin
              sda_oe_q <= ~shift_q[7];
              shift_q  <= {shift_q[6:0], 1'b1};
            end
          end
          RD_ACK: begin
            if (scl_fall && !ack_ph_q) begin
              sda_oe_q <= 1'b0;
              ack_ph_q <= 1'b1;
            end else if (scl_rise && ack_ph_q) begin
              if (!sda_f_q) begin
                mem_rd_q <= 1'b1;
              end else begin
                state_q <= IGNORE;
              end
            end else if (scl_fall && ack_ph_q) begin
              ack_ph_q  <= 1'b0;
              bit_cnt_q <= 3'd0;
              sda_oe_q  <= ~shift_q[7];
              shift_q   <= {shift_q[6:0], 1'b1};
              state_q   <= RD_BYTE;
            end
          end
          IDLE, IGNORE: begin
            sda_oe_q <= 1'b0;
          end
          default: begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_frame_slave.md
# i2c_frame_slave

Parametrised, single-clock I2C slave giving the host MCU random and streaming access to the spinning-screen frame buffer, addressed as segment (angular slice) × word offset. It oversamples and filters SCL/SDA in the system clock domain and detects START/STOP, repeated START and ACK/NACK. It drives an external synchronous frame-buffer RAM port with auto-incrementing pointers, so the whole frame can be loaded or read back in one burst.

## Interface
Parameters:
- DEV_ADDR, 7'h50 — 7-bit slave address (wire bytes 8'hA0 write / 8'hA1 read).
- SEG_W, 8 — segment pointer width (1..8).
- OFF_W, 8 — offset pointer width (1..8).
- NUM_SEG, 256 — valid segments, ≤ 2^SEG_W.
- NUM_OFF, 256 — words per segment, ≤ 2^OFF_W.
- FILT, 3 — clk cycles a synchronised level must be stable before it is accepted (≥1).
- CARRY, 1 — 1: offset wrap increments segment; 0: offset wraps within the segment.

Ports:
- clk  in  1  system clock; only clock.
- rst_n  in  1  asynchronous, active-low reset.
- scl_i  in  1  SCL pad input, asynchronous.
- sda_i  in  1  SDA pad input, asynchronous.
- sda_oe  out  1  1 = pull SDA low (open drain); reset 0.
- mem_addr  out  SEG_W+OFF_W  {seg_ptr, off_ptr}; reset 0.
- mem_rd  out  1  one-cycle read strobe; mem_rdata valid next cycle; reset 0.
- mem_rdata  in  8  read data.
- mem_wr  out  1  one-cycle write strobe with mem_addr/mem_wdata; reset 0.
- mem_wdata  out  8  write data; reset 0.
- busy  out  1  high from START addressing this slave until STOP/mismatch; reset 0.
- seg_ptr  out  SEG_W  current segment pointer; reset 0.
- off_ptr  out  OFF_W  current offset pointer; reset 0.

## Operation
- Input path: 2-FF synchroniser per line, then FILT-cycle stability filter → scl_f, sda_f. Edges are detected on filtered signals only.
- START = sda_f falls while scl_f high; STOP = sda_f rises while scl_f high. Either one aborts any state: sda_oe ← 0, byte counter cleared. START → ADDR; STOP → IDLE. Pointers retain their values.
- States: IDLE, ADDR, ADDR_ACK, IGNORE, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
- Data is sampled MSB first on scl_f rising; sda_oe changes only on scl_f falling.
- ADDR: after 8 bits, if addr[7:1]==DEV_ADDR → ADDR_ACK (busy=1); else IGNORE (no drive until next START/STOP).
- ACK: slave holds sda_oe=1 from the 8th falling edge to the 9th falling edge.
- Write transaction (R/W=0): byte index 0 = segment, 1 = offset, ≥2 = data.
  - Segment byte ≥ NUM_SEG, or offset byte ≥ NUM_OFF → NACK, pointer unchanged, → IGNORE.
  - Data byte: ACK, mem_wr pulse for one cycle on the 9th rising edge at the current pointer, then pointer increments.
- Read transaction (R/W=1): on the ACK falling edge, mem_rd pulses at the current pointer. The latched byte is shifted out over RD_BYTE; the pointer increments after the byte is latched.
  - On the 9th rising edge: master ACK (sda_f=0) → prefetch the next byte and continue; NACK → release and go to IDLE-wait.
- Increment: off_ptr+1. At NUM_OFF-1 it wraps to 0, and if CARRY the segment also increments. Segment NUM_SEG-1 wraps to 0.
- Repeated START after the offset byte → new address phase; the pointer set by the write is used by a following read.
- rst_n low: all registers and outputs reset immediately, SDA released within the same instant (async).

## Timing
- Input-to-decision latency: 2 + FILT clk cycles; requires SCL high/low ≥ FILT+4 clk cycles (400 kHz at ≥ 12 MHz clk, FILT=3).
- mem_rd → mem_rdata latched 1 cycle later, well before the first SCL rising edge of the byte.
- mem_wr is exactly 1 cycle wide and occurs once per accepted data byte.
- busy falls 1 cycle after STOP detection or address mismatch.
- No clock stretching: SCL is never driven.

## Test plan
- Write A0, 03, 10, then data AB, CD, then STOP → ACK all; mem_wr at addr 0x0310=AB and 0x0311=CD; final seg_ptr=03, off_ptr=12.
- Write A0, 05, 00; repeated START; A1; read 3 bytes (ACK, ACK, NACK) → mem_rd at 0x0500–0x0502; SDA bytes equal model RAM; busy drops after STOP.
- Address 0xB0 → no ACK, sda_oe stays 0 throughout, no mem strobes, busy=0.
- NUM_OFF=256, CARRY=1: pointer 07/FF, write 2 bytes → addresses 0x07FF, 0x0800. With CARRY=0 → 0x07FF, 0x0700.
- Segment byte 0xF0 with NUM_SEG=200 → NACK on that byte, pointer unchanged, subsequent bytes ignored.
- Assert rst_n mid-read with sda_oe=1 → sda_oe=0 immediately; pointers 0; after release, a 1-clk SDA glitch (< FILT) during SCL high → no START detected.
